// File: rtl/priority_ctrl_sequencer_if.sv
// Request, configuration-write and control-word bundle for priority_ctrl_sequencer.
// The sequencer connects through the slave modport; the driving side uses master.
interface priority_ctrl_sequencer_if #(
   parameter int unsigned NUM_REQ = 5,
   parameter int unsigned CTRL_W  = 8,
   parameter int unsigned SEQ_LEN = 4
);
   localparam int unsigned CH_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

   logic [NUM_REQ-1:0] req;
   logic               cfg_we;
   logic [CH_W-1:0]    cfg_ch;
   logic [STEP_W-1:0]  cfg_step;
   logic               cfg_len_sel;
   logic [CTRL_W-1:0]  cfg_data;
   logic [CTRL_W-1:0]  ctrl;
   logic               busy;
   logic [CH_W-1:0]    act_ch;
   logic               done;

   modport slave (
      input  req, cfg_we, cfg_ch, cfg_step, cfg_len_sel, cfg_data,
      output ctrl, busy, act_ch, done
   );

   modport master (
      output req, cfg_we, cfg_ch, cfg_step, cfg_len_sel, cfg_data,
      input  ctrl, busy, act_ch, done
   );
endinterface

// File: rtl/priority_ctrl_sequencer.sv
// Priority-arbitrated control-word sequencer: the winning request channel plays
// its run-time programmable micro-sequence onto a registered control word.
module priority_ctrl_sequencer #(
   parameter int unsigned           NUM_REQ   = 5,
   parameter int unsigned           CTRL_W    = 8,
   parameter int unsigned           SEQ_LEN   = 4,
   parameter int unsigned           PREEMPT   = 0,
   parameter logic [CTRL_W-1:0]     IDLE_WORD = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   priority_ctrl_sequencer_if.slave   bus
);

   localparam int unsigned CH_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam int unsigned LEN_W  = $clog2(SEQ_LEN + 1);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t              r_state, w_state_nx;
   logic [STEP_W-1:0]   r_step, w_step_nx;
   logic [CH_W-1:0]     r_act_ch, w_act_nx;
   logic [CTRL_W-1:0]   r_ctrl, w_ctrl_nx;
   logic                r_busy, w_busy_nx;
   logic                r_done, w_done_nx;

   logic [CTRL_W-1:0]   r_word [NUM_REQ][SEQ_LEN];
   logic [LEN_W-1:0]    r_len  [NUM_REQ];
   logic [LEN_W-1:0]    w_len_nxt [NUM_REQ];

   logic                w_any;
   logic [CH_W-1:0]     w_win;
   logic                w_cfg_ch_ok, w_cfg_st_ok, w_word_we, w_len_we;
   logic [LEN_W-1:0]    w_len_wdata;
   logic                w_last, w_preempt, w_start;

   // Lowest set request index wins
   always_comb begin
      w_any = |bus.req;
      w_win = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req[i]) w_win = CH_W'(i);
      end
   end

   // Write decode; lengths are clamped into 1..SEQ_LEN before storage
   always_comb begin
      w_cfg_ch_ok = 32'(bus.cfg_ch) < NUM_REQ;
      w_cfg_st_ok = 32'(bus.cfg_step) < SEQ_LEN;
      w_word_we   = bus.cfg_we && !bus.cfg_len_sel && w_cfg_ch_ok && w_cfg_st_ok;
      w_len_we    = bus.cfg_we &&  bus.cfg_len_sel && w_cfg_ch_ok;
      if (bus.cfg_data == '0)
         w_len_wdata = LEN_W'(32'd1);
      else if (32'(bus.cfg_data) > SEQ_LEN)
         w_len_wdata = LEN_W'(SEQ_LEN);
      else
         w_len_wdata = LEN_W'(bus.cfg_data);
      for (int i = 0; i < NUM_REQ; i++) begin
         w_len_nxt[i] = (w_len_we && bus.cfg_ch == CH_W'(i)) ? w_len_wdata : r_len[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_REQ; c++) begin
            r_len[c] <= LEN_W'(32'd1);
            for (int s = 0; s < SEQ_LEN; s++) r_word[c][s] <= IDLE_WORD;
         end
      end else begin
         if (w_word_we) r_word[bus.cfg_ch][bus.cfg_step] <= bus.cfg_data;
         for (int c = 0; c < NUM_REQ; c++) r_len[c] <= w_len_nxt[c];
      end
   end

   // Next-state and output logic; done is predicted against the post-edge length
   always_comb begin
      w_state_nx = r_state;
      w_step_nx  = r_step;
      w_act_nx   = r_act_ch;
      w_ctrl_nx  = r_ctrl;
      w_busy_nx  = r_busy;
      w_done_nx  = 1'b0;
      w_start    = 1'b0;
      w_last     = 32'(r_len[r_act_ch]) <= 32'(r_step) + 32'd1;
      w_preempt  = (PREEMPT != 0) && w_any && (w_win < r_act_ch);

      case (r_state)
         ST_IDLE: w_start = w_any;
         ST_RUN: begin
            if (w_last || w_preempt) begin
               w_start = w_any;
               if (!w_any) begin
                  w_state_nx = ST_IDLE;
                  w_busy_nx  = 1'b0;
               end
            end else begin
               w_step_nx = r_step + STEP_W'(1);
               w_ctrl_nx = r_word[r_act_ch][w_step_nx];
               w_done_nx = 32'(w_len_nxt[r_act_ch]) <= 32'(r_step) + 32'd2;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase

      if (w_start) begin
         w_state_nx = ST_RUN;
         w_act_nx   = w_win;
         w_step_nx  = '0;
         w_ctrl_nx  = r_word[w_win][0];
         w_busy_nx  = 1'b1;
         w_done_nx  = 32'(w_len_nxt[w_win]) <= 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_step   <= '0;
         r_act_ch <= '0;
         r_ctrl   <= IDLE_WORD;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_step   <= w_step_nx;
         r_act_ch <= w_act_nx;
         r_ctrl   <= w_ctrl_nx;
         r_busy   <= w_busy_nx;
         r_done   <= w_done_nx;
      end
   end

   assign bus.ctrl   = r_ctrl;
   assign bus.busy   = r_busy;
   assign bus.act_ch = r_act_ch;
   assign bus.done   = r_done;

endmodule

// File: doc/priority_ctrl_sequencer.md
# priority_ctrl_sequencer

Registered, parametrised priority control unit. Drives a `CTRL_W`-bit control word from one of `NUM_REQ` prioritised request lines. Each request plays a programmable micro-sequence of up to `SEQ_LEN` control words, one word per clock, instead of producing a single fixed combinational pattern. The block sits between the request/decode logic and the datapath it steers, with the control words loaded at run time through a simple write port.

## Interface
Parameters:
- `NUM_REQ`, 5: number of request channels; channel 0 has the highest priority.
- `CTRL_W`, 8: control word width.
- `SEQ_LEN`, 4: maximum words per channel sequence.
- `PREEMPT`, 0: 1 means a strictly higher-priority request aborts a running sequence.
- `IDLE_WORD`, 8'b0000_0000 (`CTRL_W` bits): reset value of `ctrl` and of every table entry.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  `NUM_REQ`  level request lines, sampled on `clk`.
- `cfg_we`  in  1  table/length write strobe.
- `cfg_ch`  in  clog2(`NUM_REQ`)  channel addressed by the write.
- `cfg_step`  in  clog2(`SEQ_LEN`)  step addressed by a word write.
- `cfg_len_sel`  in  1  0 = write `cfg_data` to word[`cfg_ch`][`cfg_step`]; 1 = write length[`cfg_ch`] from `cfg_data` LSBs.
- `cfg_data`  in  `CTRL_W`  write data.
- `ctrl`  out  `CTRL_W`  registered control word.
- `busy`  out  1  sequence in progress.
- `act_ch`  out  clog2(`NUM_REQ`)  channel being played or last played.
- `done`  out  1  one-cycle pulse coincident with the last word of a sequence.

## Operation
- Storage: word table of `NUM_REQ`×`SEQ_LEN`×`CTRL_W` flops and a length register per channel.
- Reset state: word table = `IDLE_WORD`, lengths = 1, `ctrl` = `IDLE_WORD`, `busy` = 0, `done` = 0, `act_ch` = 0, FSM in IDLE, step = 0.
- Effective length: written value 0 is stored as 1; values greater than `SEQ_LEN` are stored as `SEQ_LEN`.
- Writes with out-of-range `cfg_ch` or `cfg_step` are ignored.
- Arbitration: the lowest set index of `req` wins. With no request, nothing starts.
- FSM states:
  - IDLE: `ctrl` holds its last value (explicit hold, no latch). On an edge with `req` nonzero, load `act_ch` = winner, step = 0, `ctrl` = word[winner][0], go to RUN.
  - RUN: each edge advances step and sets `ctrl` = word[act_ch][step].
- Length-1 sequences: they never occupy more than one cycle in RUN.
- Last step (step = len-1): `done` = 1. On the next edge, arbitration is repeated exactly as in IDLE.
  - If a winner exists, its step 0 loads immediately, with no bubble.
  - If no winner exists, go to IDLE, `busy` falls, and `ctrl` keeps the last word.
- `req` deassertion mid-sequence does not stop the sequence. The sequence always runs to completion unless it is preempted.
- Preemption (`PREEMPT` = 1): in RUN, if some `req[i]` is set with i < `act_ch`, the next edge restarts at word[i][0] with `act_ch` = i. No `done` is issued for the aborted sequence. Requests with equal or lower priority never preempt. With `PREEMPT` = 0, requests are ignored until the last step.
- Config writes during RUN:
  - Table reads are from current flop contents.
  - A write to a step not yet played is visible when that step is reached.
  - A length write to the running channel applies from the next edge. If the new length is ≤ the current step, the current step is treated as the last step.

## Timing
- Latency: `req` high before edge N puts word 0 on `ctrl` after edge N. Word k appears after edge N+k.
- `busy` is registered, high from edge N through the cycle that shows the last word.
- `done` is registered, high only during the cycle that shows the last word.
- Config writes take effect at the edge where `cfg_we` is sampled high.
- Asynchronous reset mid-sequence: all outputs return to their reset values immediately. The first request after `rst_n` deasserts starts at step 0.

## Test plan
- Reset, then program ch2 words {0x11,0x22,0x33}, len 3; pulse `req`=5'b00100 for one cycle. Required: `ctrl` shows 0x11, 0x22, 0x33 on 3 consecutive cycles; `done` only with 0x33; `ctrl` then holds 0x33 with `busy`=0.
- `req`=5'b10011 held with ch0 len 2 and ch1 len 1. Required: ch0 plays first. After its last word, ch0 plays again with no idle cycle, because req[0] is still set. Drop req[0], and ch1 plays next.
- `PREEMPT`=1, ch3 running (len 4); assert req[1] during step 1. Required: the next `ctrl` is word[1][0], `act_ch`=1, and no `done` for ch3. Repeat with `PREEMPT`=0: ch3 completes all 4 words first.
- Length writes of 0 and 9 with `SEQ_LEN`=4. Required: sequences of length 1 and 4 respectively.
- Assert `rst_n`=0 mid-sequence, asynchronously between edges. Required: `ctrl`=`IDLE_WORD` and `busy`=`done`=0 immediately; table contents are back to `IDLE_WORD`.
- While ch0 runs len 4, write word[0][3]=0xA5 during step 1. Required: step 3 outputs 0xA5.
